// File: rtl/key_debounce.sv
// key_debounce: per-key synchronizer plus counter debounce FSM with press/release/long-press pulses
module key_debounce #(
    parameter int   N_KEYS          = 2,
    parameter int   DEBOUNCE_CYCLES = 20000,
    parameter int   LONG_CYCLES     = 500000,
    parameter int   CNT_W           = 20,
    parameter logic KEY_ACTIVE      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HC_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] HC_FIRE = CNT_W'(LONG_CYCLES - 1);

    logic [N_KEYS-1:0] r_sync1, r_sync2;
    logic [N_KEYS-1:0] w_pressed_raw;

    assign w_pressed_raw = key_raw ~^ {N_KEYS{KEY_ACTIVE}};

    // two-flop synchronizer, normalised so 1 always means pressed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pressed_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t           r_state, w_next;
        logic [CNT_W-1:0] r_dc, r_hc, w_dc, w_hc;
        logic             r_level, r_press, r_release, r_long;
        logic             w_level, w_press, w_release, w_long;
        logic             w_ks, w_dc_done, w_hold;

        assign w_ks      = r_sync2[k];
        assign w_dc_done = r_dc == DC_LAST;
        assign w_hold    = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

        // state, counters and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= IDLE;
                r_dc      <= '0;
                r_hc      <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_state   <= w_next;
                r_dc      <= w_dc;
                r_hc      <= w_hc;
                r_level   <= w_level;
                r_press   <= w_press;
                r_release <= w_release;
                r_long    <= w_long;
            end
        end

        // next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples
        always_comb begin
            w_next = r_state;
            case (r_state)
                IDLE:         w_next = w_ks ? PRESS_WAIT : IDLE;
                PRESS_WAIT:   w_next = !w_ks ? IDLE : w_dc_done ? PRESSED : PRESS_WAIT;
                PRESSED:      w_next = !w_ks ? RELEASE_WAIT : PRESSED;
                RELEASE_WAIT: w_next = w_ks ? PRESSED : w_dc_done ? IDLE : RELEASE_WAIT;
                default:      w_next = IDLE;
            endcase
        end

        // outputs and counter updates; hold counter saturates so key_long fires once per press
        always_comb begin
            w_press   = (r_state == PRESS_WAIT) && w_ks && w_dc_done;
            w_release = (r_state == RELEASE_WAIT) && !w_ks && w_dc_done;
            w_long    = w_hold && (r_hc == HC_FIRE);
            w_level   = (w_next == PRESSED) || (w_next == RELEASE_WAIT);
            w_dc      = ((r_state == IDLE) && w_ks) || ((r_state == PRESSED) && !w_ks) ? CNT_W'(1) :
                        (((r_state == PRESS_WAIT) && w_ks) || ((r_state == RELEASE_WAIT) && !w_ks)) && !w_dc_done ?
                        r_dc + CNT_W'(1) : '0;
            w_hc      = w_press ? '0 : (w_hold && (r_hc != HC_MAX)) ? r_hc + CNT_W'(1) : r_hc;
        end

        assign key_level[k]   = r_level;
        assign key_press[k]   = r_press;
        assign key_release[k] = r_release;
        assign key_long[k]    = r_long;
    end
endmodule
